mc_datapath: RTL and testbench

//  Datapath of the multicycle CPU, directly downstream of the control unit.

---
 rtl/mc_datapath_if.sv | 45 ++++
 rtl/mc_datapath.sv | 132 +++++++++++++
 tb/tb_mc_datapath.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// Control/memory bundle between the multicycle datapath and its control unit.
// The master side is the control unit (strobes) together with the unified memory
// (read data); the slave side is the datapath (decode fields, z, address/data, debug views).
interface mc_datapath_if;
    // control strobes from the control unit
    logic        wpc;
    logic        wir;
    logic        wmem;
    logic        wreg;
    logic        iord;
    logic        regrt;
    logic        m2reg;
    logic        shift;
    logic        alusrca;
    logic        jal;
    logic        sext;
    logic [3:0]  aluc;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsource;
    // decode feedback to the control unit
    logic [5:0]  op;
    logic [5:0]  func;
    logic        z;
    // unified instruction/data memory
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    // debug views
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu_out;

    modport master (
        output wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
        output aluc, alusrcb, pcsource, mem_rdata,
        input  op, func, z, mem_addr, mem_wdata, mem_we, pc, ir, alu_out
    );

    modport slave (
        input  wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
        input  aluc, alusrcb, pcsource, mem_rdata,
        output op, func, z, mem_addr, mem_wdata, mem_we, pc, ir, alu_out
    );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle CPU datapath: PC, IR, A, B, C, MDR, 32x32 register file and ALU.
// Latency: every register updates on the rising clock edge; z, alu_out, mem_addr are combinational.
// Backpressure: none; the control unit sequences IF/ID/EXE/MEM/WB and the memory reads same-cycle.
// Ports: clock, resetn (async, active low); bus (slave modport) carries control strobes in,
//        op/func/z out, memory address/write data/write enable out, read data in, debug pc/ir/alu_out.
module mc_datapath #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          resetn,
    mc_datapath_if.slave  bus
);

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] c_q;
    logic [31:0] mdr_q;
    logic [31:0] rf [32];

    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ext16;
    logic [31:0] br_off;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_sra;
    logic [31:0] alu_res;
    logic [31:0] npc;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign rs_addr = ir_q[25:21];
    assign rt_addr = ir_q[20:16];
    assign rd_addr = ir_q[15:11];

    // r0 is never written, but the explicit zero keeps reads independent of that
    assign rs_val = (rs_addr == 5'd0) ? 32'h0 : rf[rs_addr];
    assign rt_val = (rt_addr == 5'd0) ? 32'h0 : rf[rt_addr];

    assign ext16  = bus.sext ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0, ir_q[15:0]};
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    // shift amount comes from the shamt field, the value to shift arrives on the B side
    assign alu_a = bus.alusrca ? pc_q : (bus.shift ? {27'h0, ir_q[10:6]} : a_q);

    always_comb begin
        alu_b = b_q;
        case (bus.alusrcb)
            2'd0:    alu_b = b_q;
            2'd1:    alu_b = 32'd4;
            2'd2:    alu_b = ext16;
            default: alu_b = br_off;
        endcase
    end

    assign alu_sra = $unsigned($signed(alu_b) >>> alu_a[4:0]);

    // aluc[3] only distinguishes arithmetic from logical right shift
    always_comb begin
        alu_res = 32'h0;
        case (bus.aluc[2:0])
            3'b000:  alu_res = alu_a + alu_b;
            3'b100:  alu_res = alu_a - alu_b;
            3'b001:  alu_res = alu_a & alu_b;
            3'b101:  alu_res = alu_a | alu_b;
            3'b010:  alu_res = alu_a ^ alu_b;
            3'b110:  alu_res = {alu_b[15:0], 16'h0};
            3'b011:  alu_res = alu_b << alu_a[4:0];
            default: alu_res = bus.aluc[3] ? alu_sra : (alu_b >> alu_a[4:0]);
        endcase
    end

    // source 2 reads the register file directly so jr can retire in ID before A is loaded;
    // source 3 uses PC, which already holds the incremented address after IF
    always_comb begin
        npc = alu_res;
        case (bus.pcsource)
            2'd0:    npc = alu_res;
            2'd1:    npc = c_q;
            2'd2:    npc = rs_val;
            default: npc = {pc_q[31:28], ir_q[25:0], 2'b00};
        endcase
    end

    // jal stores the pre-jump PC (the return address) in the same edge PC takes the target
    assign wr_addr = bus.jal ? 5'd31 : (bus.regrt ? rt_addr : rd_addr);
    assign wr_data = bus.jal ? pc_q : (bus.m2reg ? mdr_q : c_q);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_q  <= PC_RESET;
            ir_q  <= 32'h0;
            a_q   <= 32'h0;
            b_q   <= 32'h0;
            c_q   <= 32'h0;
            mdr_q <= 32'h0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'h0;
            end
        end else begin
            a_q   <= rs_val;
            b_q   <= rt_val;
            c_q   <= alu_res;
            mdr_q <= bus.mem_rdata;
            if (bus.wir) begin
                ir_q <= bus.mem_rdata;
            end
            if (bus.wpc) begin
                pc_q <= npc;
            end
            if (bus.wreg && (wr_addr != 5'd0)) begin
                rf[wr_addr] <= wr_data;
            end
        end
    end

    assign bus.op        = ir_q[31:26];
    assign bus.func      = ir_q[5:0];
    assign bus.z         = (alu_res == 32'h0);
    assign bus.mem_addr  = bus.iord ? c_q : pc_q;
    assign bus.mem_wdata = b_q;
    assign bus.mem_we    = bus.wmem;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.alu_out   = alu_res;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: acts as control unit and unified memory, runs directed and random
// programs, and compares fetch addresses, stores and probed outputs against an ISA-level model.
module tb_mc_datapath;

    localparam logic [31:0] PC_RESET = 32'h0000_0000;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    mc_datapath_if bus ();
    mc_datapath #(.PC_RESET(PC_RESET)) dut (.clock(clock), .resetn(resetn), .bus(bus));

    logic [31:0] mem [1024];
    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

    typedef struct { bit store; logic [31:0] addr; logic [31:0] data; } ev_t;
    typedef enum int {P_NONE, P_PC, P_IR, P_OP, P_FUNC, P_Z, P_ALU, P_MADDR, P_SBLEFT} psel_t;
    typedef struct { psel_t sel; logic [31:0] exp; string name; } probe_t;

    ev_t    exp_q[$];
    probe_t probe_q[$];
    bit     probe_vld = 1'b0;
    bit     fetch_phase = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;

    // ISA-level reference state
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_r [32];
    logic [31:0] ref_pc;

    // ---------------- monitor / scoreboard ----------------
    function automatic void sb_check(bit is_store, logic [31:0] a, logic [31:0] d);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got store=%0d addr %h data %h, expected no event", is_store, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.store !== is_store || e.addr !== a || (is_store && e.data !== d)) begin
                n_fail++;
                $display("FAIL sb_event: got store=%0d addr %h data %h, expected store=%0d addr %h data %h",
                         is_store, a, d, e.store, e.addr, e.data);
            end
        end
    endfunction

    function automatic void run_probe(probe_t p);
        logic [31:0] act;
        case (p.sel)
            P_PC:     act = bus.pc;
            P_IR:     act = bus.ir;
            P_OP:     act = {26'h0, bus.op};
            P_FUNC:   act = {26'h0, bus.func};
            P_Z:      act = {31'h0, bus.z};
            P_ALU:    act = bus.alu_out;
            P_MADDR:  act = bus.mem_addr;
            P_SBLEFT: act = 32'(exp_q.size());
            default:  act = 32'hDEAD_BEEF;
        endcase
        n_checks++;
        if (act !== p.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", p.name, act, p.exp);
        end
    endfunction

    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (fetch_phase) sb_check(1'b0, bus.mem_addr, 32'h0);
            if (bus.mem_we === 1'b1) sb_check(1'b1, bus.mem_addr, bus.mem_wdata);
        end
        if (probe_vld) begin
            while (probe_q.size() > 0) run_probe(probe_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time budget exceeded, got no end of test");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic ref_reset();
        ref_pc = PC_RESET;
        for (int i = 0; i < 32; i++) ref_r[i] = 32'h0;
    endtask

    task automatic ref_wr(input logic [4:0] d, input logic [31:0] v);
        if (d != 5'd0) ref_r[d] = v;
    endtask

    // executes one instruction; exe_val is the value the instruction computes
    // (result, effective address, or rs-rt for branches)
    task automatic ref_step(output logic [31:0] exe_val);
        logic [31:0] ins, rs, rt, imm_s, imm_z, ea;
        logic [4:0]  sh;
        ins   = ref_mem[ref_pc[11:2]];
        exp_q.push_back('{1'b0, ref_pc, 32'h0});
        ref_pc = ref_pc + 32'd4;
        rs    = ref_r[ins[25:21]];
        rt    = ref_r[ins[20:16]];
        imm_s = {{16{ins[15]}}, ins[15:0]};
        imm_z = {16'h0, ins[15:0]};
        sh    = ins[10:6];
        exe_val = 32'h0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20: exe_val = rs + rt;
                    6'h22: exe_val = rs - rt;
                    6'h24: exe_val = rs & rt;
                    6'h25: exe_val = rs | rt;
                    6'h26: exe_val = rs ^ rt;
                    6'h00: exe_val = rt << sh;
                    6'h02: exe_val = rt >> sh;
                    6'h03: exe_val = $unsigned($signed(rt) >>> sh);
                    default: exe_val = 32'h0;
                endcase
                if (ins[5:0] == 6'h08) ref_pc = rs;
                else ref_wr(ins[15:11], exe_val);
            end
            6'h08: begin exe_val = rs + imm_s; ref_wr(ins[20:16], exe_val); end
            6'h0C: begin exe_val = rs & imm_z; ref_wr(ins[20:16], exe_val); end
            6'h0D: begin exe_val = rs | imm_z; ref_wr(ins[20:16], exe_val); end
            6'h0E: begin exe_val = rs ^ imm_z; ref_wr(ins[20:16], exe_val); end
            6'h0F: begin exe_val = {ins[15:0], 16'h0}; ref_wr(ins[20:16], exe_val); end
            6'h23: begin
                ea = rs + imm_s; exe_val = ea;
                ref_wr(ins[20:16], ref_mem[ea[11:2]]);
            end
            6'h2B: begin
                ea = rs + imm_s; exe_val = ea;
                ref_mem[ea[11:2]] = rt;
                exp_q.push_back('{1'b1, ea, rt});
            end
            6'h04: begin exe_val = rs - rt; if (rs == rt) ref_pc = ref_pc + (imm_s << 2); end
            6'h05: begin exe_val = rs - rt; if (rs != rt) ref_pc = ref_pc + (imm_s << 2); end
            6'h02: ref_pc = {ref_pc[31:28], ins[25:0], 2'b00};
            6'h03: begin ref_wr(5'd31, ref_pc); ref_pc = {ref_pc[31:28], ins[25:0], 2'b00}; end
            default: ;
        endcase
    endtask

    // ---------------- control unit ----------------
    task automatic clear_ctl();
        bus.wpc = 0; bus.wir = 0; bus.wmem = 0; bus.wreg = 0; bus.iord = 0; bus.regrt = 0;
        bus.m2reg = 0; bus.shift = 0; bus.alusrca = 0; bus.jal = 0; bus.sext = 0;
        bus.aluc = 4'h0; bus.alusrcb = 2'd0; bus.pcsource = 2'd0;
    endtask

    task automatic probe(input psel_t s, input logic [31:0] e, input string n);
        probe_q.push_back('{s, e, n});
        probe_vld = 1'b1;
    endtask

    task automatic tick();
        logic        we_s;
        logic [31:0] a_s, d_s;
        @(negedge clock);
        we_s = bus.mem_we; a_s = bus.mem_addr; d_s = bus.mem_wdata;
        @(posedge clock);
        #1;
        if (we_s === 1'b1) mem[a_s[11:2]] = d_s;
        clear_ctl();
        fetch_phase = 1'b0;
        probe_vld = 1'b0;
    endtask

    function automatic logic [3:0] alu_code(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'b0000;
            6'h22: return 4'b0100;
            6'h24: return 4'b0001;
            6'h25: return 4'b0101;
            6'h26: return 4'b0010;
            6'h00: return 4'b0011;
            6'h02: return 4'b0111;
            6'h03: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic start_instr(output logic [31:0] ins, output logic [31:0] ev);
        ins = ref_mem[ref_pc[11:2]];
        ref_step(ev);
        bus.wpc = 1; bus.wir = 1; bus.alusrca = 1; bus.alusrcb = 2'd1;
        fetch_phase = 1'b1;
        tick();
    endtask

    task automatic finish_instr(input logic [31:0] ins, input logic [31:0] ev,
                                input psel_t xsel, input logic [31:0] xexp,
                                input psel_t msel, input logic [31:0] mexp);
        logic [5:0] op, fn;
        bit r_type, branch, memop;
        op = ins[31:26]; fn = ins[5:0];
        r_type = (op == 6'h00);
        branch = (op == 6'h04) || (op == 6'h05);
        memop  = (op == 6'h23) || (op == 6'h2B);
        // ID: branch target into C, or retire jumps
        bus.alusrca = 1; bus.alusrcb = 2'd3;
        if (op == 6'h02 || op == 6'h03) begin
            bus.wpc = 1; bus.pcsource = 2'd3;
            if (op == 6'h03) begin bus.wreg = 1; bus.jal = 1; end
            tick();
            return;
        end
        if (r_type && fn == 6'h08) begin
            bus.wpc = 1; bus.pcsource = 2'd2;
            tick();
            return;
        end
        tick();
        // EXE
        if (r_type) begin
            bus.shift = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03);
            bus.aluc = alu_code(fn);
        end else begin
            bus.alusrcb = branch ? 2'd0 : 2'd2;
            case (op)
                6'h0C: bus.aluc = 4'b0001;
                6'h0D: bus.aluc = 4'b0101;
                6'h0E: bus.aluc = 4'b0010;
                6'h0F: bus.aluc = 4'b0110;
                6'h04, 6'h05: bus.aluc = 4'b0100;
                default: begin bus.aluc = 4'b0000; bus.sext = 1; end
            endcase
        end
        probe(P_ALU, ev, "exe_alu");
        if (branch) probe(P_Z, {31'h0, ev == 32'h0}, "exe_z");
        if (xsel != P_NONE) probe(xsel, xexp, "exe_directed");
        if (branch) begin
            #1;
            if ((op == 6'h04) == (bus.z === 1'b1)) begin bus.wpc = 1; bus.pcsource = 2'd1; end
        end
        tick();
        if (branch) return;
        // MEM
        if (memop) begin
            bus.iord = 1; bus.wmem = (op == 6'h2B);
            if (msel != P_NONE) probe(msel, mexp, "mem_directed");
            tick();
            if (op == 6'h2B) return;
        end
        // WB
        bus.wreg = 1; bus.regrt = !r_type; bus.m2reg = (op == 6'h23);
        tick();
    endtask

    task automatic run_instr();
        logic [31:0] ins, ev;
        start_instr(ins, ev);
        finish_instr(ins, ev, P_NONE, 32'h0, P_NONE, 32'h0);
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
        ref_mem[a[11:2]] = w;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_ctl();
        ref_reset();
        probe(P_PC, PC_RESET, "reset_pc");
        probe(P_IR, 32'h0, "reset_ir");
        probe(P_OP, 32'h0, "reset_op");
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] gen_rand();
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] imm;
        int k;
        k  = int'($urandom_range(0, 10));
        rs = 5'($urandom_range(0, 31));
        rt = 5'($urandom_range(0, 31));
        rd = 5'($urandom_range(0, 31));
        sh = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case (k)
            0: return {6'h00, rs, rt, rd, 5'h0, 6'h20};
            1: return {6'h00, rs, rt, rd, 5'h0, 6'h22};
            2: return {6'h00, rs, rt, rd, 5'h0, 6'h24};
            3: return {6'h00, rs, rt, rd, 5'h0, 6'h25};
            4: return {6'h00, rs, rt, rd, 5'h0, 6'h26};
            5: begin
                case ($urandom_range(0, 2))
                    0: return {6'h00, 5'h0, rt, rd, sh, 6'h00};
                    1: return {6'h00, 5'h0, rt, rd, sh, 6'h02};
                    default: return {6'h00, 5'h0, rt, rd, sh, 6'h03};
                endcase
            end
            6: return {6'h08, rs, rt, imm};
            7: return {6'(6'h0C + 6'($urandom_range(0, 2))), rs, rt, imm};
            8: return {6'h0F, 5'h0, rt, imm};
            9: return {6'h23, 5'h0, rt, 16'(16'h0800 + 16'(4 * $urandom_range(0, 511)))};
            default: return {6'h2B, 5'h0, rt, 16'(16'h0800 + 16'(4 * $urandom_range(0, 511)))};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ins, ev;
        clear_ctl();
        for (int i = 0; i < 1024; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end

        // directed program: arithmetic, memory, branches, sra, then reset inside EXE
        load_word(32'h00, 32'h2001_0005);   // addi $1,$0,5
        load_word(32'h04, 32'h0021_1020);   // add  $2,$1,$1
        load_word(32'h08, 32'hAC02_0008);   // sw   $2,8($0)
        load_word(32'h0C, 32'h8C03_0008);   // lw   $3,8($0)
        load_word(32'h10, 32'h1021_FFFF);   // beq  $1,$1,-1
        load_word(32'h14, 32'h3C04_8000);   // lui  $4,0x8000
        load_word(32'h18, 32'h0004_2903);   // sra  $5,$4,4
        load_word(32'h1C, 32'hAC05_0800);   // sw   $5,0x800($0)
        load_word(32'h20, 32'hAC00_0804);   // sw   $0,0x804($0)
        load_word(32'h24, 32'hAC01_0808);   // sw   $1,0x808($0)
        load_word(32'h28, 32'hAC03_080C);   // sw   $3,0x80C($0)
        load_word(32'h2C, 32'h0021_3020);   // add  $6,$1,$1
        do_reset();

        start_instr(ins, ev);
        probe(P_IR, 32'h2001_0005, "if_ir");
        probe(P_PC, 32'h4, "if_pc");
        probe(P_OP, 32'h8, "if_op");
        finish_instr(ins, ev, P_NONE, 32'h0, P_NONE, 32'h0);
        start_instr(ins, ev);
        probe(P_FUNC, 32'h20, "if_func");
        finish_instr(ins, ev, P_NONE, 32'h0, P_NONE, 32'h0);
        start_instr(ins, ev);
        finish_instr(ins, ev, P_NONE, 32'h0, P_MADDR, 32'h8);
        run_instr();
        start_instr(ins, ev);
        finish_instr(ins, ev, P_Z, 32'h1, P_NONE, 32'h0);
        probe(P_PC, 32'h10, "beq_pc");
        tick();
        load_word(32'h10, 32'h1421_FFFF);   // bne $1,$1,-1
        run_instr();
        probe(P_PC, 32'h14, "bne_pc");
        tick();
        run_instr();
        start_instr(ins, ev);
        finish_instr(ins, ev, P_ALU, 32'hF800_0000, P_NONE, 32'h0);
        repeat (4) run_instr();

        // add $6: reset lands in the middle of EXE
        start_instr(ins, ev);
        bus.alusrca = 1; bus.alusrcb = 2'd3;
        tick();
        bus.aluc = 4'b0000;
        #2;
        resetn = 1'b0;
        ref_reset();
        probe(P_PC, PC_RESET, "midexe_rst_pc");
        probe(P_IR, 32'h0, "midexe_rst_ir");
        tick();
        resetn = 1'b1;

        // jal / jr from the reset PC
        load_word(32'h000, 32'h0C00_0040);  // jal 0x40
        load_word(32'h100, 32'h03E0_0008);  // jr  $31
        load_word(32'h004, 32'hAC1F_0800);  // sw  $31,0x800($0)
        load_word(32'h008, 32'hAC01_0804);  // sw  $1,0x804($0)
        run_instr();
        probe(P_PC, 32'h100, "jal_pc");
        tick();
        run_instr();
        probe(P_PC, 32'h4, "jr_pc");
        tick();
        run_instr();
        run_instr();

        // random straight-line program followed by a dump of every register
        for (int i = 512; i < 1024; i++) load_word(32'(i * 4), $urandom);
        for (int i = 0; i < 60; i++) load_word(32'(i * 4), gen_rand());
        for (int i = 0; i < 32; i++) load_word(32'((60 + i) * 4), {6'h2B, 5'h0, 5'(i), 16'(16'h0F00 + 16'(4 * i))});
        do_reset();
        for (int i = 0; i < 92; i++) run_instr();

        probe(P_SBLEFT, 32'h0, "sb_leftover");
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
